// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: geometry constants and entry types.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;

    typedef enum logic [1:0] {
        RobTReg    = 2'd0,
        RobTBranch = 2'd1,
        RobTStore  = 2'd2,
        RobTRsvd   = 2'd3
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue.
// Allocates a tag per issued instruction, captures CDB results and commits the head in program
// order, one entry per cycle. A mispredicted branch flushes the whole buffer at its commit edge.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (low freezes state and registered outputs)
//   issue_*     : allocation request; issue_tag is the tag it receives, rob_full stalls issue
//   cdb_*       : result broadcast into a busy entry
//   query_*     : combinational operand lookup with same-cycle CDB bypass
//   set_reg/set_val, set_reg_q_2/set_val_q_2 : regfile write and tag-clear on REG commit
//   store_commit/store_commit_tag : STORE retire pulse
//   flush_out/redirect_pc         : mispredict flush pulse and fetch target
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned RobDepth = ROB_DEPTH,
    parameter int unsigned TagW     = TAG_W,
    parameter int unsigned DataW    = DATA_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    output logic [TagW-1:0]  issue_tag,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [TagW-1:0]  cdb_tag,
    input  logic [DataW-1:0] cdb_value,
    input  logic             cdb_mispredict,
    input  logic [TagW-1:0]  query_tag_1,
    input  logic [TagW-1:0]  query_tag_2,
    output logic             query_ready_1,
    output logic             query_ready_2,
    output logic [DataW-1:0] query_val_1,
    output logic [DataW-1:0] query_val_2,
    output logic [4:0]       set_reg,
    output logic [DataW-1:0] set_val,
    output logic [4:0]       set_reg_q_2,
    output logic [DataW-1:0] set_val_q_2,
    output logic             store_commit,
    output logic [TagW-1:0]  store_commit_tag,
    output logic             flush_out,
    output logic [DataW-1:0] redirect_pc
);

    // Entry storage as parallel arrays.
    logic             busy_q    [RobDepth];
    logic             ready_q   [RobDepth];
    rob_type_e        type_q    [RobDepth];
    logic [4:0]       rd_q      [RobDepth];
    logic [DataW-1:0] value_q   [RobDepth];
    logic             mispred_q [RobDepth];

    logic [TagW-1:0] head_q, head_d, tail_q, tail_d;
    logic [TagW:0]   count_q, count_d;

    logic [4:0]       set_reg_q, set_reg_d, set_reg2_q, set_reg2_d;
    logic [DataW-1:0] set_val_q, set_val_d, set_val2_q, set_val2_d;
    logic             store_q, store_d, flush_q, flush_d;
    logic [TagW-1:0]  store_tag_q, store_tag_d;
    logic [DataW-1:0] redirect_q, redirect_d;

    logic commit, flush, do_issue, do_cdb;

    assign issue_tag = tail_q;
    assign rob_full  = (count_q == (TagW + 1)'(RobDepth));

    // Flush wins over everything on its edge: same-edge issue and CDB are dropped.
    always_comb begin
        commit   = rdy_in && busy_q[head_q] && ready_q[head_q];
        flush    = commit && (type_q[head_q] == RobTBranch) && mispred_q[head_q];
        do_issue = rdy_in && issue_valid && !rob_full && !flush;
        do_cdb   = rdy_in && cdb_valid && busy_q[cdb_tag] && !flush;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit) head_d = head_q + TagW'(1);
            if (do_issue) tail_d = tail_q + TagW'(1);
            if (do_issue && !commit) begin
                count_d = count_q + (TagW + 1)'(1);
            end else if (!do_issue && commit) begin
                count_d = count_q - (TagW + 1)'(1);
            end
        end
    end

    // Commit outputs are zero unless a commit happened at the previous edge; frozen when !rdy_in.
    always_comb begin
        set_reg_d   = set_reg_q;
        set_val_d   = set_val_q;
        set_reg2_d  = set_reg2_q;
        set_val2_d  = set_val2_q;
        store_d     = store_q;
        store_tag_d = store_tag_q;
        flush_d     = flush_q;
        redirect_d  = redirect_q;
        if (rdy_in) begin
            set_reg_d   = '0;
            set_val_d   = '0;
            set_reg2_d  = '0;
            set_val2_d  = '0;
            store_d     = 1'b0;
            store_tag_d = '0;
            flush_d     = 1'b0;
            redirect_d  = '0;
            if (commit) begin
                case (type_q[head_q])
                    RobTReg: begin
                        if (rd_q[head_q] != 5'd0) begin
                            set_reg_d  = rd_q[head_q];
                            set_val_d  = value_q[head_q];
                            set_reg2_d = rd_q[head_q];
                            set_val2_d = DataW'(head_q);
                        end
                    end
                    RobTStore: begin
                        store_d     = 1'b1;
                        store_tag_d = head_q;
                    end
                    RobTBranch: begin
                        if (mispred_q[head_q]) begin
                            flush_d    = 1'b1;
                            redirect_d = value_q[head_q];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RobDepth; i++) begin
                busy_q[i]    <= 1'b0;
                ready_q[i]   <= 1'b0;
                type_q[i]    <= RobTReg;
                rd_q[i]      <= '0;
                value_q[i]   <= '0;
                mispred_q[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < RobDepth; i++) begin
                busy_q[i] <= 1'b0;
            end
        end else begin
            if (commit) busy_q[head_q] <= 1'b0;
            if (do_issue) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                type_q[tail_q]  <= rob_type_e'(issue_type);
                rd_q[tail_q]    <= issue_rd;
            end
            if (do_cdb) begin
                value_q[cdb_tag]   <= cdb_value;
                mispred_q[cdb_tag] <= cdb_mispredict;
                ready_q[cdb_tag]   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            set_reg_q   <= '0;
            set_val_q   <= '0;
            set_reg2_q  <= '0;
            set_val2_q  <= '0;
            store_q     <= 1'b0;
            store_tag_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            set_reg_q   <= set_reg_d;
            set_val_q   <= set_val_d;
            set_reg2_q  <= set_reg2_d;
            set_val2_q  <= set_val2_d;
            store_q     <= store_d;
            store_tag_q <= store_tag_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
        end
    end

    assign set_reg          = set_reg_q;
    assign set_val          = set_val_q;
    assign set_reg_q_2      = set_reg2_q;
    assign set_val_q_2      = set_val2_q;
    assign store_commit     = store_q;
    assign store_commit_tag = store_tag_q;
    assign flush_out        = flush_q;
    assign redirect_pc      = redirect_q;

    // Operand lookup: committed-ready entry first, then same-cycle CDB bypass.
    always_comb begin
        query_ready_1 = 1'b0;
        query_val_1   = '0;
        query_ready_2 = 1'b0;
        query_val_2   = '0;
        if (busy_q[query_tag_1] && ready_q[query_tag_1]) begin
            query_ready_1 = 1'b1;
            query_val_1   = value_q[query_tag_1];
        end else if (cdb_valid && (cdb_tag == query_tag_1)) begin
            query_ready_1 = 1'b1;
            query_val_1   = cdb_value;
        end
        if (busy_q[query_tag_2] && ready_q[query_tag_2]) begin
            query_ready_2 = 1'b1;
            query_val_2   = value_q[query_tag_2];
        end else if (cdb_valid && (cdb_tag == query_tag_2)) begin
            query_ready_2 = 1'b1;
            query_val_2   = cdb_value;
        end
    end

endmodule
